// File: rtl/stream_scr_par.sv
// rtl/stream_scr_par.sv - 100BASE-T1 side-stream scrambler with self-synchronising descrambler lock FSM
module stream_scr_par #(
    parameter int DW       = 1,
    parameter int LOCK_CNT = 15,
    parameter int WIN      = 64,
    parameter int ERR_MAX  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          load,
    input  logic [32:0]   seed,
    input  logic          valid,
    input  logic          sync_en,
    input  logic [DW-1:0] rx_bits,
    output logic [DW-1:0] scr_bits,
    output logic          scr_vld,
    output logic          mism,
    output logic          locked,
    output logic [1:0]    sync_state,
    output logic          seed_zero
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam int         FILL_BEATS = (33 + DW - 1) / DW;
    localparam logic [5:0] FILL_LAST  = 6'(FILL_BEATS - 1);
    localparam logic [7:0] LOCK_LAST  = 8'(LOCK_CNT - 1);
    localparam logic [9:0] WIN_LAST   = 10'(WIN - 1);
    localparam logic [10:0] ERR_LIM   = 11'(ERR_MAX);
    localparam logic [32:0] S_RESET   = 33'h1_FFFF_FFFF;

    state_t        state_q, state_d;
    logic [32:0]   s_q, s_d;
    logic [DW-1:0] scr_bits_q, scr_bits_d;
    logic          scr_vld_q, scr_vld_d;
    logic          mism_q, mism_d;
    logic          seed_zero_q, seed_zero_d;
    logic [5:0]    fill_cnt_q, fill_cnt_d;
    logic [7:0]    clean_cnt_q, clean_cnt_d;
    logic [9:0]    win_cnt_q, win_cnt_d;
    logic [10:0]   err_cnt_q, err_cnt_d;

    logic [32:0]   run_s;
    logic [32:0]   fill_s;
    logic [DW-1:0] gen_bits;
    logic          mismatch;
    logic [10:0]   err_next;

    // Unrolled DW-step LFSR advance, plus the FILL path that shifts received bits in instead.
    always_comb begin
        run_s    = s_q;
        fill_s   = s_q;
        gen_bits = '0;
        for (int k = 0; k < DW; k++) begin
            gen_bits[k] = run_s[32] ^ (mode ? run_s[19] : run_s[12]);
            run_s       = {run_s[31:0], gen_bits[k]};
            fill_s      = {fill_s[31:0], rx_bits[k]};
        end
        mismatch = (gen_bits != rx_bits);
        err_next = err_cnt_q + {10'd0, mismatch};
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        scr_bits_d  = scr_bits_q;
        scr_vld_d   = 1'b0;
        mism_d      = 1'b0;
        seed_zero_d = seed_zero_q;
        fill_cnt_d  = fill_cnt_q;
        clean_cnt_d = clean_cnt_q;
        win_cnt_d   = win_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (!sync_en) begin
            state_d = ST_IDLE;
            if (load) begin
                if (seed == 33'd0) begin
                    s_d         = S_RESET;
                    seed_zero_d = 1'b1;
                end else begin
                    s_d = seed;
                end
            end else if (valid) begin
                s_d        = run_s;
                scr_bits_d = gen_bits;
                scr_vld_d  = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_FILL;
                    fill_cnt_d = '0;
                end
                ST_FILL: begin
                    if (valid) begin
                        s_d        = fill_s;
                        scr_bits_d = rx_bits;
                        scr_vld_d  = 1'b1;
                        if (fill_cnt_q == FILL_LAST) begin
                            state_d     = ST_CHECK;
                            fill_cnt_d  = '0;
                            clean_cnt_d = '0;
                        end else begin
                            fill_cnt_d = fill_cnt_q + 6'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (valid) begin
                        s_d        = run_s;
                        scr_bits_d = gen_bits;
                        scr_vld_d  = 1'b1;
                        mism_d     = mismatch;
                        if (mismatch) begin
                            state_d    = ST_FILL;
                            fill_cnt_d = '0;
                        end else if (clean_cnt_q == LOCK_LAST) begin
                            state_d   = ST_LOCKED;
                            win_cnt_d = '0;
                            err_cnt_d = '0;
                        end else begin
                            clean_cnt_d = clean_cnt_q + 8'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (valid) begin
                        s_d        = run_s;
                        scr_bits_d = gen_bits;
                        scr_vld_d  = 1'b1;
                        mism_d     = mismatch;
                        // Too many errors beats a simultaneous window rollover.
                        if (err_next > ERR_LIM) begin
                            state_d    = ST_FILL;
                            fill_cnt_d = '0;
                        end else if (win_cnt_q == WIN_LAST) begin
                            win_cnt_d = '0;
                            err_cnt_d = '0;
                        end else begin
                            win_cnt_d = win_cnt_q + 10'd1;
                            err_cnt_d = err_next;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= S_RESET;
            scr_bits_q  <= '0;
            scr_vld_q   <= 1'b0;
            mism_q      <= 1'b0;
            seed_zero_q <= 1'b0;
            fill_cnt_q  <= '0;
            clean_cnt_q <= '0;
            win_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            scr_bits_q  <= scr_bits_d;
            scr_vld_q   <= scr_vld_d;
            mism_q      <= mism_d;
            seed_zero_q <= seed_zero_d;
            fill_cnt_q  <= fill_cnt_d;
            clean_cnt_q <= clean_cnt_d;
            win_cnt_q   <= win_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign scr_bits   = scr_bits_q;
    assign scr_vld    = scr_vld_q;
    assign mism       = mism_q;
    assign locked     = (state_q == ST_LOCKED);
    assign sync_state = state_q;
    assign seed_zero  = seed_zero_q;

endmodule

// File: doc/stream_scr_par.md
# stream_scr_par

Parametrised side-stream scrambler/descrambler-sync block for the 100BASE-T1 PCS. It generates DW scrambler bits per beat from a 33-bit LFSR, with the master (1+x^13+x^33) or slave (1+x^20+x^33) polynomial selected at run time. In sync mode it self-synchronises to a received scrambled idle stream and reports lock. It sits between the PCS encoder/decoder and the 3B/2T mapper, one instance per direction.

## Interface
- DW, 1, scrambler bits produced per valid beat (1..33)
- LOCK_CNT, 15, consecutive clean beats in CHECK required to declare lock (1..255)
- WIN, 64, error-monitor window length in beats while LOCKED (2..1023)
- ERR_MAX, 4, mismatched beats tolerated per window; more drops lock
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- mode  in  1  0 = master polynomial (tap bit 12), 1 = slave polynomial (tap bit 19); sampled each beat
- load  in  1  load seed into LFSR (generate mode only)
- seed  in  33  LFSR seed
- valid  in  1  advance one beat
- sync_en  in  1  1 = descrambler-sync mode, 0 = generate mode
- rx_bits  in  DW  received scrambled bits, bit 0 earliest, qualified by valid
- scr_bits  out  DW  scrambler bits, bit 0 earliest, registered
- scr_vld  out  1  scr_bits valid strobe
- mism  out  1  predicted vs rx_bits mismatch on last beat (CHECK/LOCKED only)
- locked  out  1  sync FSM in LOCKED
- sync_state  out  2  0 IDLE, 1 FILL, 2 CHECK, 3 LOCKED
- seed_zero  out  1  sticky: an all-zero seed was substituted

## Operation
- LFSR state s[32:0]. One step: n = s[32] ^ s[T] (T=12 master, T=19 slave); s <= {s[31:0], n}; step output bit = n. A beat performs DW steps in one cycle; step k output goes to scr_bits[k].
- Generate mode (sync_en=0), priority rst > load > valid: load sets s=seed; a zero seed loads 33'h1_FFFF_FFFF and sets seed_zero. valid advances one beat. Otherwise s holds. load and valid together: load wins, no output.
- Sync FSM (sync_en=1; load ignored):
  - IDLE: on sync_en=1 -> FILL, fill counter cleared.
  - FILL: each valid beat shifts rx_bits directly into s (rx_bits[0] first); after ceil(33/DW) beats -> CHECK, clean counter = 0.
  - CHECK: each valid beat free-runs LFSR, compares step outputs with rx_bits. Any mismatch -> FILL (mism=1). Else clean counter++; reaching LOCK_CNT -> LOCKED, window and error counters = 0.
  - LOCKED: free-runs; mismatched beat increments error counter. Error counter > ERR_MAX -> FILL immediately. Window counter reaching WIN clears both counters.
  - sync_en=0 in any state -> IDLE next cycle; s retained.
- Generate mode with sync_state != IDLE cannot occur; FSM is IDLE whenever sync_en=0.
- mode change mid-stream takes effect on the next beat; no flush.

## Timing
- Reset values: s=33'h1_FFFF_FFFF, scr_bits=0, scr_vld=0, mism=0, locked=0, sync_state=0, seed_zero=0; all counters 0.
- Latency: scr_bits/scr_vld/mism registered, 1 cycle after the valid beat. FILL beats produce scr_vld=1 with scr_bits = rx_bits.
- sync_state/locked update on the cycle after the deciding beat.
- Zero-seed substitution and seed_zero assert 1 cycle after load; seed_zero clears only on rst.
- rst mid-FILL/CHECK/LOCKED: everything returns to reset values next edge; sync restarts from IDLE.
- Throughput: one beat per cycle, back-to-back valid supported; no backpressure.

## Test plan
- DW=4, mode=1, load seed=33'h1_0000_0000, one valid -> scr_bits=4'b0001, scr_vld=1 one cycle later; repeat with mode=0 -> same first beat; compare 10k beats of both modes against bit-serial reference model.
- load seed=0 -> s=33'h1_FFFF_FFFF, seed_zero=1; subsequent beats match model from that state.
- DW=3, sync_en=1, rx_bits from generator in slave mode -> FILL 11 beats, CHECK 15 clean beats, locked=1 cycle after beat 26; mism stays 0.
- LOCKED, inject 5 single-bit errors within one 64-beat window -> unlock to FILL after the 5th; inject 4 -> stays LOCKED, counters clear at window end.
- Error injected in CHECK beat 7 -> mism=1, back to FILL, lock delayed by full FILL+CHECK.
- Assert rst while LOCKED and valid high -> all outputs at reset values next cycle; deassert sync_en mid-CHECK -> IDLE, locked=0.
